ahb_dual_mem_arbiter: RTL and testbench
=======================================

# ahb_dual_mem_arbiter

Shares one single-port synchronous SRAM (one access per cycle, read data valid the next cycle) between the SCR1 instruction AHB-Lite port and the data AHB-Lite port. It replaces the dual-ported ROM path so that code and data can live in one writable on-chip RAM. The block sits between `scr1_top_ahb` and the SRAM macro. On the dmem side it is one slave behind `ahb_slave_mux`; on the imem side it is the only slave.

## Interface
Parameters:
- `AW`, 13: SRAM word-address width. Word address is `haddr[AW+1:2]`; higher bits are decoded outside the block via `hsel`.
- `DW`, 32: data width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock (cpu_clk).
- `rst`  in  1  synchronous, active-high reset.
- `imem_hsel`  in  1  imem slave select.
- `imem_htrans`  in  2  imem HTRANS.
- `imem_haddr`  in  32  imem HADDR.
- `imem_hready`  out  1  imem HREADY (sole slave, so in and out are the same signal).
- `imem_hrdata`  out  32  imem read data.
- `imem_hresp`  out  1  imem HRESP.
- `dmem_hsel`  in  1  dmem slave select.
- `dmem_htrans`  in  2  dmem HTRANS.
- `dmem_haddr`  in  32  dmem HADDR.
- `dmem_hsize`  in  3  dmem HSIZE.
- `dmem_hwrite`  in  1  dmem HWRITE.
- `dmem_hwdata`  in  32  dmem HWDATA (data phase).
- `dmem_hready_in`  in  1  shared dmem HREADY from the mux.
- `dmem_hreadyout`  out  1  this slave's HREADYOUT.
- `dmem_hrdata`  out  32  dmem read data.
- `dmem_hresp`  out  1  dmem HRESP.
- `mem_req`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write.
- `mem_be`  out  4  SRAM byte enables.
- `mem_addr`  out  AW  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid the cycle after `mem_req && !mem_we`.

## Operation
- **Address-phase capture.** A transfer is accepted when all of these hold:
  - `hsel` is 1;
  - `htrans[1]` is 1 (NONSEQ or SEQ);
  - HREADY is 1 (`imem_hready` for imem, `dmem_hready_in` for dmem).
  
  The block latches address, size and write into the port's pending slot. IDLE and BUSY transfers are ignored and get a zero-wait OKAY.
- **dmem checks at capture.** The block checks `hsize` and alignment:
  - `hsize > 2` is illegal;
  - halfword with `haddr[0]=1` is illegal;
  - word with `haddr[1:0]!=0` is illegal.
  
  An illegal transfer never reaches the SRAM. It gets a two-cycle ERROR response: cycle 1 `hreadyout=0, hresp=1`; cycle 2 `hreadyout=1, hresp=1`.
- **Byte enables.** Byte: `4'b0001<<a[1:0]`. Halfword: `4'b0011<<{a[1],1'b0}`. Word: `4'b1111`. The imem port always reads with `be=4'hF`.
- **Write data.** A dmem write becomes eligible in its data-phase cycle, when `hwdata` is valid. If it is not granted that cycle, `hwdata` is latched into a write buffer.
- **Per-port FSM.** States are `IDLE`, `WAIT_GRANT`, `RD_DATA`, `ERR1`, `ERR2`.
  - `IDLE`: capture goes to `WAIT_GRANT`, or to `ERR1` for an illegal transfer.
  - `WAIT_GRANT`: a granted read goes to `RD_DATA`. A granted write completes in the grant cycle (`hready=1`) and goes to `IDLE`.
  - `RD_DATA`: drives `hrdata=mem_rdata` with `hready=1`. Goes to `IDLE`, or straight back to `WAIT_GRANT` if a new transfer is captured in the same cycle (back-to-back).
  - `ERR1` goes to `ERR2`; `ERR2` goes to `IDLE` (or capture).
- **Arbitration.** One grant per cycle among ports in `WAIT_GRANT`, using 2-way round-robin.
  - A `last` bit records the most recent winner.
  - On conflict the other port wins.
  - A lone requester always wins and does not wait for rotation.
  - Worst-case wait is one extra cycle per transfer.
- **Read data is registered.** `hrdata` holds its last value outside `RD_DATA`.

## Timing
- Uncontested read: capture at cycle N, `mem_req` at N+1, `hready=1` with data at N+2. One wait state.
- Uncontested write: capture at N, `mem_req/mem_we` at N+1 with `hready=1`. Zero wait states.
- Contested: the loser adds exactly one cycle.
- Reset values:
  - `imem_hready=1`, `dmem_hreadyout=1`;
  - `*_hresp=0`, `*_hrdata=0`;
  - `mem_req=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`;
  - `last=0` (dmem wins the first conflict).
- Reset asserted mid-transfer: all pending slots and the write buffer are dropped, and the next cycle shows the reset values. No SRAM write is issued in the reset cycle.
- `dmem_hready_in=0` from another slave's wait: no dmem capture, and any dmem state in progress is unaffected.
- When not in `WAIT_GRANT`/`RD_DATA`/`ERR`, `hreadyout` is 1.

## Structure
- Package `ahb_mem_arb_pkg` holds:
  - `HTRANS_*` and `HSIZE_*` localparams;
  - the `port_state_e` enum;
  - the `req_s` struct (addr, be, we, err);
  - the function `ahb_be(hsize, addr_lo)`.
- Sub-module `rr_arb2`: a 2-requester round-robin with a registered `last` bit. Inputs `req[1:0]`; output one-hot `gnt[1:0]`.
- Two port-FSM instances are written inline. The imem instance ties `hwrite=0` and `hsize=2`.

## Test plan
- Reset with both ports idle: reset values on every output; the first read of word 0x10 returns `mem_rdata` at N+2 with `imem_hready` low for exactly one cycle.
- dmem word write 0xDEADBEEF to 0x40, then a read from 0x40: `mem_we=1`, `be=F`, `addr=0x10` at N+1; the read returns 0xDEADBEEF.
- Same-cycle imem read and dmem write after reset: dmem is granted first; the imem read completes one cycle later; on the next conflict imem wins.
- dmem byte write 0x55 to 0x43: `mem_be=4'b1000`, `mem_wdata` passes through the full word; halfword 0xA5A5 to 0x42: `be=4'b1100`.
- dmem word access at 0x41 (misaligned) and `hsize=3`: `hreadyout` 0→1 with `hresp=1` on both cycles; `mem_req` is never asserted.
- `rst` asserted in the cycle a dmem write is latched and waiting: no SRAM write occurs, and the outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/ahb_dual_mem_arbiter_pkg.sv
// Shared types and helpers for the imem/dmem single-port SRAM arbiter.
// Combinational helpers only; no latency and no flow control live here.
package ahb_mem_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_RD_DATA,
        ST_ERR1,
        ST_ERR2
    } port_state_e;

    // Word address is kept full width; the top slices it down to the SRAM depth.
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        err;
    } req_s;

    function automatic logic [3:0] ahb_be(input logic [2:0] hsize, input logic [1:0] addr_lo);
        case (hsize)
            HSIZE_BYTE: return 4'b0001 << addr_lo;
            HSIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic ahb_err(input logic [2:0] hsize, input logic [1:0] addr_lo);
        return (hsize > HSIZE_WORD) ||
               ((hsize == HSIZE_HALF) && addr_lo[0]) ||
               ((hsize == HSIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_dual_mem_arbiter_rr_arb2.sv
// Two-requester round-robin: combinational one-hot grant, registered last-winner bit.
// Zero latency; a lone requester wins at once, on conflict the previous loser wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last;

    always_comb begin
        gnt = req;
        if (&req)
            gnt = r_last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b0;
        else if (|req)
            r_last <= gnt[1];
    end

endmodule

// File: rtl/ahb_dual_mem_arbiter.sv
// Shares one single-port SRAM between the imem and dmem AHB-Lite ports; reads take one wait
// state, writes none; a contested loser stalls exactly one extra cycle via HREADY low.
module ahb_dual_mem_arbiter
    import ahb_mem_arb_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_hsel,
    input  logic [1:0]    imem_htrans,
    input  logic [31:0]   imem_haddr,
    output logic          imem_hready,
    output logic [DW-1:0] imem_hrdata,
    output logic          imem_hresp,
    input  logic          dmem_hsel,
    input  logic [1:0]    dmem_htrans,
    input  logic [31:0]   dmem_haddr,
    input  logic [2:0]    dmem_hsize,
    input  logic          dmem_hwrite,
    input  logic [DW-1:0] dmem_hwdata,
    input  logic          dmem_hready_in,
    output logic          dmem_hreadyout,
    output logic [DW-1:0] dmem_hrdata,
    output logic          dmem_hresp,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Port index 0 is imem, 1 is dmem.
    logic [1:0]    w_cap;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic [1:0]    w_hready;
    logic [1:0]    w_hresp;
    logic [1:0]    w_hwrite;
    logic [31:0]   w_haddr  [2];
    logic [2:0]    w_hsize  [2];
    req_s          w_slot   [2];
    logic [DW-1:0] w_hrdata [2];

    logic          r_wbuf_vld;
    logic [DW-1:0] r_wbuf;

    assign w_cap      = {dmem_hsel, imem_hsel} & {dmem_htrans[1], imem_htrans[1]} &
                        {dmem_hready_in, imem_hready};
    assign w_haddr[0] = imem_haddr;
    assign w_haddr[1] = dmem_haddr;
    assign w_hsize[0] = HSIZE_WORD;
    assign w_hsize[1] = dmem_hsize;
    assign w_hwrite   = {dmem_hwrite, 1'b0};

    for (genvar p = 0; p < 2; p++) begin : g_port
        port_state_e   r_state;
        req_s          r_slot;
        logic [DW-1:0] r_rdata;
        req_s          w_cap_req;
        logic          w_rdy;

        always_comb begin
            w_cap_req.addr = w_haddr[p][31:2];
            w_cap_req.be   = ahb_be(w_hsize[p], w_haddr[p][1:0]);
            w_cap_req.we   = w_hwrite[p];
            w_cap_req.err  = ahb_err(w_hsize[p], w_haddr[p][1:0]);
        end

        // Writes finish in their grant cycle, so a pipelined capture can land there too.
        always_comb begin
            w_rdy = 1'b1;
            case (r_state)
                ST_WAIT_GRANT: w_rdy = w_gnt[p] && r_slot.we;
                ST_ERR1:       w_rdy = 1'b0;
                default:       w_rdy = 1'b1;
            endcase
        end

        assign w_hready[p] = w_rdy;
        assign w_hresp[p]  = (r_state == ST_ERR1) || (r_state == ST_ERR2);
        assign w_req[p]    = (r_state == ST_WAIT_GRANT) && !rst;
        assign w_hrdata[p] = (r_state == ST_RD_DATA) ? mem_rdata : r_rdata;
        assign w_slot[p]   = r_slot;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_slot  <= '0;
                r_rdata <= '0;
            end else begin
                if (r_state == ST_RD_DATA)
                    r_rdata <= mem_rdata;
                if (w_rdy && w_cap[p]) begin
                    r_slot  <= w_cap_req;
                    r_state <= w_cap_req.err ? ST_ERR1 : ST_WAIT_GRANT;
                end else begin
                    case (r_state)
                        ST_WAIT_GRANT: if (w_gnt[p]) r_state <= r_slot.we ? ST_IDLE : ST_RD_DATA;
                        ST_ERR1:       r_state <= ST_ERR2;
                        default:       r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    // A losing write holds its data-phase HWDATA here until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbuf_vld <= 1'b0;
            r_wbuf     <= '0;
        end else if (w_gnt[1]) begin
            r_wbuf_vld <= 1'b0;
        end else if (w_req[1] && w_slot[1].we && !r_wbuf_vld) begin
            r_wbuf     <= dmem_hwdata;
            r_wbuf_vld <= 1'b1;
        end
    end

    always_comb begin
        mem_req   = |w_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[1]) begin
            mem_we   = w_slot[1].we;
            mem_be   = w_slot[1].be;
            mem_addr = w_slot[1].addr[AW-1:0];
            if (w_slot[1].we)
                mem_wdata = r_wbuf_vld ? r_wbuf : dmem_hwdata;
        end else if (w_gnt[0]) begin
            mem_be   = w_slot[0].be;
            mem_addr = w_slot[0].addr[AW-1:0];
        end
    end

    assign imem_hready    = w_hready[0];
    assign imem_hresp     = w_hresp[0];
    assign imem_hrdata    = w_hrdata[0];
    assign dmem_hreadyout = w_hready[1];
    assign dmem_hresp     = w_hresp[1];
    assign dmem_hrdata    = w_hrdata[1];

    logic w_unused;
    assign w_unused = ^{imem_htrans[0], dmem_htrans[0], w_slot[0].addr[29:AW],
                        w_slot[1].addr[29:AW], w_slot[0].err, w_slot[1].err};

endmodule

// File: tb/tb_ahb_dual_mem_arbiter.sv
// Directed bench for ahb_dual_mem_arbiter with a small behavioural SRAM behind it.
module tb_ahb_dual_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        imem_hsel;
    logic [1:0]  imem_htrans;
    logic [31:0] imem_haddr;
    logic        imem_hready;
    logic [31:0] imem_hrdata;
    logic        imem_hresp;
    logic        dmem_hsel;
    logic [1:0]  dmem_htrans;
    logic [31:0] dmem_haddr;
    logic [2:0]  dmem_hsize;
    logic        dmem_hwrite;
    logic [31:0] dmem_hwdata;
    logic        dmem_hready_in;
    logic        dmem_hreadyout;
    logic [31:0] dmem_hrdata;
    logic        dmem_hresp;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        other_wait;
    logic        mem_init;
    logic [31:0] sram [64];
    int          n_tot;
    int          n_bad;

    ahb_dual_mem_arbiter #(.AW(13), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_hsel      (imem_hsel),
        .imem_htrans    (imem_htrans),
        .imem_haddr     (imem_haddr),
        .imem_hready    (imem_hready),
        .imem_hrdata    (imem_hrdata),
        .imem_hresp     (imem_hresp),
        .dmem_hsel      (dmem_hsel),
        .dmem_htrans    (dmem_htrans),
        .dmem_haddr     (dmem_haddr),
        .dmem_hsize     (dmem_hsize),
        .dmem_hwrite    (dmem_hwrite),
        .dmem_hwdata    (dmem_hwdata),
        .dmem_hready_in (dmem_hready_in),
        .dmem_hreadyout (dmem_hreadyout),
        .dmem_hrdata    (dmem_hrdata),
        .dmem_hresp     (dmem_hresp),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Sole dmem slave: the mux reflects our HREADYOUT unless another slave stalls.
    assign dmem_hready_in = dmem_hreadyout & ~other_wait;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                sram[i] <= 32'h1000_0000 + i;
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b])
                    sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_req && !mem_we)
            mem_rdata <= sram[mem_addr[5:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic im(input logic s, input logic [31:0] a);
        imem_hsel   = s;
        imem_htrans = s ? 2'b10 : 2'b00;
        imem_haddr  = a;
    endtask

    task automatic dm(input logic s, input logic [31:0] a, input logic [2:0] sz, input logic w);
        dmem_hsel   = s;
        dmem_htrans = s ? 2'b10 : 2'b00;
        dmem_haddr  = a;
        dmem_hsize  = sz;
        dmem_hwrite = w;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_hready"}, imem_hready, 1);
        chk({tag, "_dmem_hreadyout"}, dmem_hreadyout, 1);
        chk({tag, "_imem_hresp"}, imem_hresp, 0);
        chk({tag, "_dmem_hresp"}, dmem_hresp, 0);
        chk({tag, "_imem_hrdata"}, imem_hrdata, 0);
        chk({tag, "_dmem_hrdata"}, dmem_hrdata, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        mem_init = 1'b1;
        rst = 1'b1;
        other_wait = 1'b0;
        im(0, 0);
        dm(0, 0, 3'd2, 0);
        dmem_hwdata = 32'h0;
        tick;
        tick;
        mem_init = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst");

        // Uncontested imem read of word 0x10: one wait state.
        im(1, 32'h40);
        #1 chk("t1_cap_hready", imem_hready, 1);
        tick;
        im(0, 0);
        #1;
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 13'h10);
        chk("t1_be", mem_be, 4'hF);
        chk("t1_we", mem_we, 0);
        chk("t1_wait", imem_hready, 0);
        tick;
        #1;
        chk("t1_done", imem_hready, 1);
        chk("t1_data", imem_hrdata, 32'h1000_0010);
        tick;
        #1 chk("t1_hold", imem_hrdata, 32'h1000_0010);

        // dmem word write then read back.
        dm(1, 32'h40, 3'd2, 1);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        dmem_hwdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_we", mem_we, 1);
        chk("t2_be", mem_be, 4'hF);
        chk("t2_addr", mem_addr, 13'h10);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_wr_rdy", dmem_hreadyout, 1);
        tick;
        dm(1, 32'h40, 3'd2, 0);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        #1 chk("t2_rd_wait", dmem_hreadyout, 0);
        tick;
        #1;
        chk("t2_rd_rdy", dmem_hreadyout, 1);
        chk("t2_rd_data", dmem_hrdata, 32'hDEAD_BEEF);
        tick;

        // Conflict after reset: dmem first, then a back-to-back conflict goes to imem.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        im(1, 32'h44);
        dm(1, 32'h48, 3'd2, 1);
        #1 tick;
        im(0, 0);
        dm(1, 32'h48, 3'd2, 0);
        dmem_hwdata = 32'h1234_5678;
        #1;
        chk("t3_d_we", mem_we, 1);
        chk("t3_d_addr", mem_addr, 13'h12);
        chk("t3_d_rdy", dmem_hreadyout, 1);
        chk("t3_i_wait", imem_hready, 0);
        tick;
        dm(0, 0, 3'd2, 0);
        #1;
        chk("t3_i_addr", mem_addr, 13'h11);
        chk("t3_i_we", mem_we, 0);
        chk("t3_i_wait2", imem_hready, 0);
        chk("t3_d_wait", dmem_hreadyout, 0);
        tick;
        #1;
        chk("t3_i_rdy", imem_hready, 1);
        chk("t3_i_data", imem_hrdata, 32'h1000_0011);
        chk("t3_d_addr2", mem_addr, 13'h12);
        chk("t3_d_wait2", dmem_hreadyout, 0);
        tick;
        #1;
        chk("t3_d_rdy2", dmem_hreadyout, 1);
        chk("t3_d_data", dmem_hrdata, 32'h1234_5678);
        tick;

        // Byte and halfword writes into word 0x10, then read the merged word.
        dm(1, 32'h43, 3'd0, 1);
        #1 tick;
        dm(1, 32'h42, 3'd1, 1);
        dmem_hwdata = 32'h5500_0000;
        #1;
        chk("t4_b_be", mem_be, 4'b1000);
        chk("t4_b_wdata", mem_wdata, 32'h5500_0000);
        chk("t4_b_addr", mem_addr, 13'h10);
        tick;
        dm(1, 32'h40, 3'd2, 0);
        dmem_hwdata = 32'hA5A5_0000;
        #1;
        chk("t4_h_be", mem_be, 4'b1100);
        chk("t4_h_wdata", mem_wdata, 32'hA5A5_0000);
        tick;
        dm(0, 0, 3'd2, 0);
        #1 tick;
        #1 chk("t4_merged", dmem_hrdata, 32'hA5A5_BEEF);
        tick;

        // Misaligned word and oversize transfer both take the two-cycle ERROR.
        dm(1, 32'h41, 3'd2, 0);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        #1;
        chk("t5a_e1_rdy", dmem_hreadyout, 0);
        chk("t5a_e1_resp", dmem_hresp, 1);
        chk("t5a_e1_req", mem_req, 0);
        tick;
        #1;
        chk("t5a_e2_rdy", dmem_hreadyout, 1);
        chk("t5a_e2_resp", dmem_hresp, 1);
        chk("t5a_e2_req", mem_req, 0);
        chk("t5a_hold", dmem_hrdata, 32'hA5A5_BEEF);
        tick;
        #1 chk("t5a_clear", dmem_hresp, 0);
        dm(1, 32'h40, 3'd3, 1);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        #1;
        chk("t5b_e1_rdy", dmem_hreadyout, 0);
        chk("t5b_e1_resp", dmem_hresp, 1);
        chk("t5b_e1_req", mem_req, 0);
        tick;
        #1;
        chk("t5b_e2_rdy", dmem_hreadyout, 1);
        chk("t5b_e2_resp", dmem_hresp, 1);
        chk("t5b_e2_req", mem_req, 0);
        tick;

        // Another slave stalling the dmem bus blocks capture.
        other_wait = 1'b1;
        dm(1, 32'h40, 3'd2, 0);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        other_wait = 1'b0;
        #1;
        chk("t7_no_req", mem_req, 0);
        chk("t7_rdy", dmem_hreadyout, 1);
        tick;

        // dmem write loses to imem, sits buffered, and reset drops it.
        im(1, 32'h44);
        dm(1, 32'h4C, 3'd2, 1);
        #1 tick;
        im(0, 0);
        dm(0, 0, 3'd2, 0);
        dmem_hwdata = 32'hCAFE_F00D;
        #1;
        chk("t6_i_addr", mem_addr, 13'h11);
        chk("t6_d_wait", dmem_hreadyout, 0);
        tick;
        dmem_hwdata = 32'h0;
        rst = 1'b1;
        #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_we", mem_we, 0);
        tick;
        rst = 1'b0;
        #1;
        chk_reset_outputs("t6");
        dm(1, 32'h4C, 3'd2, 0);
        #1 tick;
        dm(0, 0, 3'd2, 0);
        #1 tick;
        #1 chk("t6_unwritten", dmem_hrdata, 32'h1000_0013);
        tick;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
